// File: rtl/pipe_pkg.sv
// Shared pipeline types: decoded control bundle, ALU op encodings and datapath defaults.
package pipe_pkg;

    localparam int unsigned XLEN_DEF = 32;
    localparam int unsigned RA_W_DEF = 5;
    localparam int unsigned ALU_OP_W = 3;
    localparam int unsigned CNT_W    = 32;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLT = 3'b101,
        ALU_SLL = 3'b110,
        ALU_SRL = 3'b111
    } alu_op_e;

    typedef struct packed {
        logic                reg_write;
        logic                mem_to_reg;
        logic                mem_write;
        logic                alu_src;
        logic                branch;
        logic [ALU_OP_W-1:0] alu_control;
        logic                lui;
        logic                z;
        logic                g;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    // Strip side effects from a control bundle whose slot is not a real instruction.
    function automatic ctrl_t ctrl_gate(input ctrl_t c, input logic keep);
        return keep ? c : CTRL_BUBBLE;
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector: a load in EX whose destination feeds the decode slot.
module load_use_detect
    import pipe_pkg::*;
#(
    parameter int unsigned RA_W = RA_W_DEF
) (
    input  logic            valid_e,
    input  logic            mem_to_reg_e,
    input  logic [RA_W-1:0] rd_e,
    input  logic            valid_d,
    input  logic [RA_W-1:0] rs1_d,
    input  logic [RA_W-1:0] rs2_d,
    output logic            lu
);

    logic rd_nonzero;
    logic src_match;

    // rs2 is compared even for formats without it; a spurious stall is harmless.
    always_comb begin
        rd_nonzero = (rd_e != '0);
        src_match  = (rd_e == rs1_d) | (rd_e == rs2_d);
        lu         = valid_e & mem_to_reg_e & rd_nonzero & valid_d & src_match;
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush and downstream hold.
// Optional performance counters are enabled by defining ID_EX_PERF_CNT_EN.
module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF,
    parameter int unsigned RA_W = RA_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                valid_d,
    input  logic                flush_e,
    input  logic                hold_e,
    input  logic                RegWriteD,
    input  logic                MemtoRegD,
    input  logic                MemWriteD,
    input  logic                ALUSrcD,
    input  logic                BranchD,
    input  logic                luiD,
    input  logic                zD,
    input  logic                gD,
    input  logic [ALU_OP_W-1:0] ALUControlD,
    input  logic [XLEN-1:0]     RD1D,
    input  logic [XLEN-1:0]     RD2D,
    input  logic [XLEN-1:0]     ImmExtD,
    input  logic [XLEN-1:0]     PCD,
    input  logic [XLEN-1:0]     PCPlus4D,
    input  logic [RA_W-1:0]     Rs1D,
    input  logic [RA_W-1:0]     Rs2D,
    input  logic [RA_W-1:0]     RdD,
    output logic                valid_e,
    output logic                RegWriteE,
    output logic                MemtoRegE,
    output logic                MemWriteE,
    output logic                ALUSrcE,
    output logic                BranchE,
    output logic                luiE,
    output logic                zE,
    output logic                gE,
    output logic [ALU_OP_W-1:0] ALUControlE,
    output logic [XLEN-1:0]     RD1E,
    output logic [XLEN-1:0]     RD2E,
    output logic [XLEN-1:0]     ImmExtE,
    output logic [XLEN-1:0]     PCE,
    output logic [XLEN-1:0]     PCPlus4E,
    output logic [RA_W-1:0]     Rs1E,
    output logic [RA_W-1:0]     Rs2E,
    output logic [RA_W-1:0]     RdE,
    output logic                stall_d
`ifdef ID_EX_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]    bubble_cnt,
    output logic [CNT_W-1:0]    flush_cnt,
    output logic [CNT_W-1:0]    hold_cnt
`endif
);

    ctrl_t ctrl_d;
    ctrl_t ctrl_q;
    logic  lu;
    logic  lu_bubble;
    logic  bubble;
    logic  capture;

    always_comb begin
        ctrl_d             = CTRL_BUBBLE;
        ctrl_d.reg_write   = RegWriteD;
        ctrl_d.mem_to_reg  = MemtoRegD;
        ctrl_d.mem_write   = MemWriteD;
        ctrl_d.alu_src     = ALUSrcD;
        ctrl_d.branch      = BranchD;
        ctrl_d.alu_control = ALUControlD;
        ctrl_d.lui         = luiD;
        ctrl_d.z           = zD;
        ctrl_d.g           = gD;
    end

    load_use_detect #(
        .RA_W (RA_W)
    ) u_load_use_detect (
        .valid_e      (valid_e),
        .mem_to_reg_e (ctrl_q.mem_to_reg),
        .rd_e         (RdE),
        .valid_d      (valid_d),
        .rs1_d        (Rs1D),
        .rs2_d        (Rs2D),
        .lu           (lu)
    );

    // Edge action: flush beats hold beats load-use bubble beats normal capture.
    always_comb begin
        lu_bubble = 1'b0;
        bubble    = 1'b0;
        capture   = 1'b0;
        if (flush_e) begin
            bubble = 1'b1;
        end else if (!hold_e) begin
            if (lu) begin
                lu_bubble = 1'b1;
                bubble    = 1'b1;
            end else begin
                capture = 1'b1;
            end
        end
    end

    // Flushed decode instructions are squashed upstream, so a flush never stalls.
    assign stall_d = rst & ~flush_e & (hold_e | lu);

    // Bubbles clear only valid/control; data and indices keep their previous values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_e  <= 1'b0;
            ctrl_q   <= CTRL_BUBBLE;
            RD1E     <= '0;
            RD2E     <= '0;
            ImmExtE  <= '0;
            PCE      <= '0;
            PCPlus4E <= '0;
            Rs1E     <= '0;
            Rs2E     <= '0;
            RdE      <= '0;
        end else if (bubble) begin
            valid_e <= 1'b0;
            ctrl_q  <= CTRL_BUBBLE;
        end else if (capture) begin
            valid_e  <= valid_d;
            ctrl_q   <= ctrl_gate(ctrl_d, valid_d);
            RD1E     <= RD1D;
            RD2E     <= RD2D;
            ImmExtE  <= ImmExtD;
            PCE      <= PCD;
            PCPlus4E <= PCPlus4D;
            Rs1E     <= Rs1D;
            Rs2E     <= Rs2D;
            RdE      <= RdD;
        end
    end

    assign RegWriteE   = ctrl_q.reg_write;
    assign MemtoRegE   = ctrl_q.mem_to_reg;
    assign MemWriteE   = ctrl_q.mem_write;
    assign ALUSrcE     = ctrl_q.alu_src;
    assign BranchE     = ctrl_q.branch;
    assign ALUControlE = ctrl_q.alu_control;
    assign luiE        = ctrl_q.lui;
    assign zE          = ctrl_q.z;
    assign gE          = ctrl_q.g;

`ifdef ID_EX_PERF_CNT_EN
    // Event counters; wrap silently at 2^32.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bubble_cnt <= '0;
            flush_cnt  <= '0;
            hold_cnt   <= '0;
        end else begin
            if (lu_bubble) begin
                bubble_cnt <= bubble_cnt + CNT_W'(1);
            end
            if (flush_e) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
            if (hold_e && !flush_e) begin
                hold_cnt <= hold_cnt + CNT_W'(1);
            end
        end
    end
`else
    logic unused_lu_bubble;
    assign unused_lu_bubble = lu_bubble;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized traffic against a
// behavioural model of the stage's edge rules. Counter checks compile in with ID_EX_PERF_CNT_EN.
module tb_id_ex_stage;

    localparam int unsigned XLEN = 32;
    localparam int unsigned RA_W = 5;
    localparam int unsigned BW   = 1 + 11 + 5 * XLEN + 3 * RA_W;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic valid_d = 1'b0;
    logic flush_e = 1'b0;
    logic hold_e = 1'b0;
    logic [10:0] ctrl_d = '0;
    logic RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, BranchD, luiD, zD, gD;
    logic [2:0] ALUControlD;
    logic [XLEN-1:0] RD1D = '0, RD2D = '0, ImmExtD = '0, PCD = '0, PCPlus4D = '0;
    logic [RA_W-1:0] Rs1D = '0, Rs2D = '0, RdD = '0;

    logic valid_e, RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, BranchE, luiE, zE, gE;
    logic [2:0] ALUControlE;
    logic [XLEN-1:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
    logic [RA_W-1:0] Rs1E, Rs2E, RdE;
    logic stall_d;
`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] bubble_cnt, flush_cnt, hold_cnt;
`endif

    // ctrl_d bit map: 10 RegWrite, 9 MemtoReg, 8 MemWrite, 7 ALUSrc, 6 Branch, 5:3 ALU, 2 lui, 1 z, 0 g
    assign {RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, BranchD, ALUControlD, luiD, zD, gD} = ctrl_d;

    logic [10:0]   ctrl_obs;
    logic [BW-1:0] bundle_obs;
    assign ctrl_obs   = {RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, BranchE, ALUControlE, luiE, zE, gE};
    assign bundle_obs = {valid_e, ctrl_obs, RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE};

    id_ex_stage #(.XLEN(XLEN), .RA_W(RA_W)) dut (
        .clk(clk), .rst(rst), .valid_d(valid_d), .flush_e(flush_e), .hold_e(hold_e),
        .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .MemWriteD(MemWriteD), .ALUSrcD(ALUSrcD),
        .BranchD(BranchD), .luiD(luiD), .zD(zD), .gD(gD), .ALUControlD(ALUControlD),
        .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
        .valid_e(valid_e), .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
        .ALUSrcE(ALUSrcE), .BranchE(BranchE), .luiE(luiE), .zE(zE), .gE(gE),
        .ALUControlE(ALUControlE), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE),
        .PCPlus4E(PCPlus4E), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .stall_d(stall_d)
`ifdef ID_EX_PERF_CNT_EN
        , .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt), .hold_cnt(hold_cnt)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: what the EX slot should hold, plus event tallies.
    logic            m_valid;
    logic [10:0]     m_ctrl;
    logic [XLEN-1:0] m_rd1, m_rd2, m_imm, m_pc, m_pc4;
    logic [RA_W-1:0] m_rs1, m_rs2, m_rd;
    int unsigned     m_bubble, m_flush, m_hold;

    function automatic void model_reset();
        m_valid = 1'b0; m_ctrl = '0;
        m_rd1 = '0; m_rd2 = '0; m_imm = '0; m_pc = '0; m_pc4 = '0;
        m_rs1 = '0; m_rs2 = '0; m_rd = '0;
        m_bubble = 0; m_flush = 0; m_hold = 0;
    endfunction

    function automatic logic model_lu();
        return rst && m_valid && m_ctrl[9] && (m_rd != 0) && valid_d &&
               ((m_rd == Rs1D) || (m_rd == Rs2D));
    endfunction

    function automatic logic model_stall();
        return rst && !flush_e && (hold_e || model_lu());
    endfunction

    function automatic logic [BW-1:0] model_bundle();
        return {m_valid, m_ctrl, m_rd1, m_rd2, m_imm, m_pc, m_pc4, m_rs1, m_rs2, m_rd};
    endfunction

    function automatic void model_edge();
        if (!rst) return;
        if (flush_e) begin
            m_valid = 1'b0; m_ctrl = '0; m_flush++;
        end else if (hold_e) begin
            m_hold++;
        end else if (model_lu()) begin
            m_valid = 1'b0; m_ctrl = '0; m_bubble++;
        end else begin
            m_valid = valid_d;
            m_ctrl  = valid_d ? ctrl_d : 11'd0;
            m_rd1 = RD1D; m_rd2 = RD2D; m_imm = ImmExtD; m_pc = PCD; m_pc4 = PCPlus4D;
            m_rs1 = Rs1D; m_rs2 = Rs2D; m_rd = RdD;
        end
    endfunction

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_d(input logic v, input logic [10:0] c,
                           input logic [RA_W-1:0] r1, input logic [RA_W-1:0] r2,
                           input logic [RA_W-1:0] rd);
        valid_d = v; ctrl_d = c; Rs1D = r1; Rs2D = r2; RdD = rd;
        RD1D = 32'($urandom); RD2D = 32'($urandom); ImmExtD = 32'($urandom);
        PCD = 32'($urandom); PCPlus4D = PCD + 32'd4;
    endtask

    task automatic do_reset();
        rst = 1'b0; model_reset();
        #2;
        rst = 1'b1;
        #1;
    endtask

    localparam logic [10:0] C_LW  = 11'b110_0000_0000;
    localparam logic [10:0] C_ADD = 11'b100_0000_0000;

    task automatic test_reset();
        rst = 1'b0; flush_e = 1'b0; hold_e = 1'b1; model_reset();
        drive_d(1'b1, C_ADD, 5'd1, 5'd2, 5'd3);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bundle_obs !== '0) begin errors++; $display("FAIL reset_regs: got %h want 0", bundle_obs); end
        checks++;
        if (stall_d !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall_d); end
        rst = 1'b1; hold_e = 1'b0;
        tick();
        checks++;
        if (valid_e !== 1'b1 || RegWriteE !== 1'b1 || RD1E !== RD1D) begin
            errors++; $display("FAIL reset_first_capture: valid=%b rw=%b rd1=%h want 1 1 %h", valid_e, RegWriteE, RD1E, RD1D);
        end
        hold_e = 1'b1;
        #1;
        checks++;
        if (stall_d !== 1'b1) begin errors++; $display("FAIL hold_stall_pre_reset: got %b want 1", stall_d); end
        rst = 1'b0; model_reset();
        #1;
        checks++;
        if (bundle_obs !== '0 || stall_d !== 1'b0) begin
            errors++; $display("FAIL reset_mid_cycle: regs=%h stall=%b want 0 0", bundle_obs, stall_d);
        end
        rst = 1'b1; hold_e = 1'b0;
        tick();
    endtask

    task automatic test_load_use();
        logic [XLEN-1:0] add_rd1;
        drive_d(1'b0, '0, '0, '0, '0);
        tick();
        drive_d(1'b1, C_LW, 5'd1, 5'd2, 5'd5);
        tick();
        drive_d(1'b1, C_ADD, 5'd5, 5'd9, 5'd6);
        add_rd1 = RD1D;
        #1;
        checks++;
        if (stall_d !== 1'b1) begin errors++; $display("FAIL lu_stall: got %b want 1", stall_d); end
        tick();
        checks++;
        if (valid_e !== 1'b0 || ctrl_obs !== '0 || RdE !== 5'd5) begin
            errors++; $display("FAIL lu_bubble: valid=%b ctrl=%h rd=%0d want 0 0 5", valid_e, ctrl_obs, RdE);
        end
        checks++;
        if (stall_d !== 1'b0) begin errors++; $display("FAIL lu_stall_clear: got %b want 0", stall_d); end
        tick();
        checks++;
        if (valid_e !== 1'b1 || RD1E !== add_rd1 || RdE !== 5'd6) begin
            errors++; $display("FAIL lu_consumer: valid=%b rd1=%h rd=%0d want 1 %h 6", valid_e, RD1E, RdE, add_rd1);
        end
    endtask

    task automatic test_x0();
        drive_d(1'b0, '0, '0, '0, '0);
        tick();
        drive_d(1'b1, C_LW, 5'd1, 5'd2, 5'd0);
        tick();
        drive_d(1'b1, C_ADD, 5'd0, 5'd3, 5'd8);
        #1;
        checks++;
        if (stall_d !== 1'b0) begin errors++; $display("FAIL x0_stall: got %b want 0", stall_d); end
        tick();
        checks++;
        if (valid_e !== 1'b1 || RegWriteE !== 1'b1 || RD1E !== RD1D) begin
            errors++; $display("FAIL x0_capture: valid=%b rw=%b rd1=%h want 1 1 %h", valid_e, RegWriteE, RD1E, RD1D);
        end
    endtask

    task automatic test_flush_beats_stall();
        do_reset();
        drive_d(1'b1, C_LW, 5'd1, 5'd2, 5'd5);
        tick();
        drive_d(1'b1, C_ADD | 11'b000_0100_0000, 5'd5, 5'd9, 5'd6);
        flush_e = 1'b1;
        #1;
        checks++;
        if (stall_d !== 1'b0) begin errors++; $display("FAIL flush_stall: got %b want 0", stall_d); end
        tick();
        flush_e = 1'b0;
        checks++;
        if (valid_e !== 1'b0 || BranchE !== 1'b0 || ctrl_obs !== '0) begin
            errors++; $display("FAIL flush_bubble: valid=%b branch=%b ctrl=%h want 0 0 0", valid_e, BranchE, ctrl_obs);
        end
`ifdef ID_EX_PERF_CNT_EN
        checks++;
        if (flush_cnt !== 32'd1 || bubble_cnt !== 32'd0) begin
            errors++; $display("FAIL flush_counts: flush=%0d bubble=%0d want 1 0", flush_cnt, bubble_cnt);
        end
`endif
    endtask

    task automatic test_hold();
        logic [BW-1:0] snap;
        do_reset();
        drive_d(1'b1, C_ADD | 11'b001_1000_0000, 5'd4, 5'd6, 5'd9);
        tick();
        snap = model_bundle();
        checks++;
        if (bundle_obs !== snap) begin errors++; $display("FAIL hold_setup: got %h want %h", bundle_obs, snap); end
        hold_e = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_d(1'b1, 11'($urandom), 5'($urandom), 5'($urandom), 5'($urandom));
            #1;
            checks++;
            if (stall_d !== 1'b1) begin errors++; $display("FAIL hold_stall[%0d]: got %b want 1", i, stall_d); end
            tick();
            checks++;
            if (bundle_obs !== snap) begin errors++; $display("FAIL hold_frozen[%0d]: got %h want %h", i, bundle_obs, snap); end
        end
        hold_e = 1'b0;
        ctrl_d[9] = 1'b0;
        tick();
        checks++;
        if (valid_e !== 1'b1 || RD1E !== RD1D || {Rs1E, Rs2E, RdE} !== {Rs1D, Rs2D, RdD}) begin
            errors++; $display("FAIL hold_release: valid=%b rd1=%h want 1 %h", valid_e, RD1E, RD1D);
        end
`ifdef ID_EX_PERF_CNT_EN
        checks++;
        if (hold_cnt !== 32'd3) begin errors++; $display("FAIL hold_count: got %0d want 3", hold_cnt); end
`endif
    endtask

    task automatic test_hold_with_lu();
        drive_d(1'b0, '0, '0, '0, '0);
        tick();
        drive_d(1'b1, C_LW, 5'd1, 5'd2, 5'd12);
        tick();
        drive_d(1'b1, C_ADD, 5'd3, 5'd12, 5'd13);
        hold_e = 1'b1;
        #1;
        tick();
        checks++;
        if (valid_e !== 1'b1 || MemtoRegE !== 1'b1 || RdE !== 5'd12) begin
            errors++; $display("FAIL hold_lu_kept: valid=%b m2r=%b rd=%0d want 1 1 12", valid_e, MemtoRegE, RdE);
        end
        hold_e = 1'b0;
        #1;
        checks++;
        if (stall_d !== 1'b1) begin errors++; $display("FAIL hold_lu_restall: got %b want 1", stall_d); end
        tick();
        checks++;
        if (valid_e !== 1'b0 || ctrl_obs !== '0) begin
            errors++; $display("FAIL hold_lu_bubble: valid=%b ctrl=%h want 0 0", valid_e, ctrl_obs);
        end
        tick();
        checks++;
        if (valid_e !== 1'b1 || RdE !== 5'd13) begin
            errors++; $display("FAIL hold_lu_consumer: valid=%b rd=%0d want 1 13", valid_e, RdE);
        end
    endtask

    task automatic test_invalid_decode();
        drive_d(1'b0, 11'b101_0000_0000 | 11'($urandom_range(0, 255)), 5'd1, 5'd2, 5'd3);
        tick();
        checks++;
        if (valid_e !== 1'b0 || RegWriteE !== 1'b0 || MemWriteE !== 1'b0 || RD1E !== RD1D) begin
            errors++; $display("FAIL invalid_decode: valid=%b rw=%b mw=%b want 0 0 0", valid_e, RegWriteE, MemWriteE);
        end
    endtask

    task automatic test_back_to_back();
        logic [10:0]     q_ctrl[3] = '{C_LW, C_LW, C_ADD};
        logic [RA_W-1:0] q_rs1[3]  = '{5'd1, 5'd20, 5'd21};
        logic [RA_W-1:0] q_rd[3]   = '{5'd20, 5'd21, 5'd22};
        int idx = 0;
        int edges = 0;
        logic st;
        drive_d(1'b0, '0, '0, '0, '0);
        tick();
        while (idx < 3 && edges < 20) begin
            drive_d(1'b1, q_ctrl[idx], q_rs1[idx], 5'd2, q_rd[idx]);
            #1;
            st = model_stall();
            checks++;
            if (stall_d !== st) begin errors++; $display("FAIL b2b_stall[%0d]: got %b want %b", edges, stall_d, st); end
            tick();
            edges++;
            if (!st) idx++;
        end
        checks++;
        if (edges !== 5 || valid_e !== 1'b1 || RdE !== 5'd22) begin
            errors++; $display("FAIL b2b_sequence: edges=%0d valid=%b rd=%0d want 5 1 22", edges, valid_e, RdE);
        end
    endtask

    task automatic test_random();
        logic          st;
        logic [BW-1:0] exp_b;
        for (int i = 0; i < 400; i++) begin
            drive_d(($urandom % 8) != 0, 11'($urandom), 5'($urandom_range(0, 3)),
                    5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
            flush_e = ($urandom % 10) == 0;
            hold_e  = ($urandom % 8) == 0;
            #1;
            st = model_stall();
            checks++;
            if (stall_d !== st) begin errors++; $display("FAIL rand_stall[%0d]: got %b want %b", i, stall_d, st); end
            tick();
            exp_b = model_bundle();
            checks++;
            if (bundle_obs !== exp_b) begin errors++; $display("FAIL rand_regs[%0d]: got %h want %h", i, bundle_obs, exp_b); end
        end
        flush_e = 1'b0;
        hold_e  = 1'b0;
`ifdef ID_EX_PERF_CNT_EN
        checks++;
        if (bubble_cnt !== m_bubble || flush_cnt !== m_flush || hold_cnt !== m_hold) begin
            errors++; $display("FAIL rand_counts: b=%0d f=%0d h=%0d want %0d %0d %0d",
                               bubble_cnt, flush_cnt, hold_cnt, m_bubble, m_flush, m_hold);
        end
`endif
    endtask

    initial begin
        model_reset();
        test_reset();
        test_load_use();
        test_x0();
        test_flush_beats_stall();
        test_hold();
        test_hold_with_lu();
        test_invalid_decode();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, errors=%0d", errors + 1);
        $fatal(1);
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute pipeline register of the 5-stage core; sits directly downstream of the decode-stage controller.
- Captures the decoded control bundle (RegWrite, MemtoReg, MemWrite, ALUSrc, Branch, ALUControl, lui, z, g), the register operands, the immediate and PC values, and the register indices.
- Owns load-use hazard detection: it stalls fetch/decode and injects a bubble into EX.
- Honours a branch flush from EX and a hold from downstream.

Parameters:
- XLEN, 32, datapath width.
- RA_W, 5, register-index width.

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  reset; asynchronous, active-low
- valid_d  in  1  decode slot holds a real instruction
- flush_e  in  1  squash the instruction entering EX (branch taken)
- hold_e  in  1  freeze the EX register (downstream stall)
- RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, BranchD, luiD, zD, gD  in  1 each  controller outputs
- ALUControlD  in  3  ALU operation
- RD1D, RD2D, ImmExtD, PCD, PCPlus4D  in  XLEN each  decode data
- Rs1D, Rs2D, RdD  in  RA_W each  register indices
- valid_e  out  1  EX slot holds a real instruction
- RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, BranchE, luiE, zE, gE  out  1 each
- ALUControlE  out  3
- RD1E, RD2E, ImmExtE, PCE, PCPlus4E  out  XLEN each
- Rs1E, Rs2E, RdE  out  RA_W each
- stall_d  out  1  combinational; hold PC and IF/ID register this cycle

Behaviour:
- Reset (rst=0, asynchronous): every registered output is 0, including valid_e and all control and data fields. stall_d=0 while in reset.
- Load-use condition:
  - lu = valid_e & MemtoRegE & (RdE!=0) & valid_d & ((RdE==Rs1D) | (RdE==Rs2D)).
  - Rs2D is compared for all instruction types; this is conservative by design.
- Per-edge priority:
  1. flush_e=1: bubble loaded. valid_e=0; all control outputs 0; data/index fields keep their previous values.
  2. else hold_e=1: all E registers keep their values.
  3. else lu=1: bubble loaded, exactly as in case 1.
  4. else: all D inputs captured; valid_e<=valid_d. If valid_d=0, control outputs are forced to 0.
- stall_d = !flush_e & (hold_e | lu). A flush never stalls, because the decode instruction is being squashed upstream.
- Latency:
  - 1 cycle D to E.
  - A load-use stall lasts exactly one cycle. After the bubble, valid_e=0, so lu clears automatically.
- Back-to-back loads: each dependent consumer gets its own single bubble.
- hold_e together with lu: hold wins, no bubble is inserted, and lu is re-evaluated after the hold releases.
- rst asserted mid-stall: the register clears immediately, and stall_d drops in the same cycle.
- No arithmetic in the block; widths pass through unchanged.

Optional Feature:
- Macro: ID_EX_PERF_CNT_EN.
- When defined, three extra outputs are present:
  - bubble_cnt (32): increments on every load-use bubble.
  - flush_cnt (32): increments on every edge with flush_e=1.
  - hold_cnt (32): increments on every edge with hold_e=1 and flush_e=0.
- Counters reset to 0 on rst, wrap at 2^32 silently, and do not count while in reset.
- When undefined, the ports and logic are absent, and the core behaviour is otherwise identical.

Decomposition:
- Shared package (pipe_pkg):
  - ctrl_t struct: RegWrite, MemtoReg, MemWrite, ALUSrc, Branch, ALUControl[2:0], lui, z, g.
  - CTRL_BUBBLE constant: all zero.
  - ALUControl encodings.
  - XLEN and RA_W defaults.
- One sub-module, load_use_detect: purely combinational, produces lu from the E and D fields. It is reused later by the forwarding unit.

Test Plan:
- Reset: drive rst=0 mid-cycle with valid_d=1 and RegWriteD=1 -> all outputs 0 immediately; after release, the first edge captures D fields with valid_e=1 and RegWriteE=1.
- Load-use:
  - Setup: EX holds lw x5 (MemtoRegE=1, RdE=5, valid_e=1); D holds add with Rs1D=5.
  - Response: stall_d=1. Next edge gives valid_e=0 and all controls 0, then stall_d=0. The following edge captures the add with RD1D propagated to RD1E.
- x0 exemption: same as the load-use case but RdE=0 and Rs1D=0 -> stall_d=0, and the add enters EX without a bubble.
- Flush beats stall: lu true and flush_e=1 in the same cycle -> stall_d=0, next valid_e=0 and BranchE=0. With ID_EX_PERF_CNT_EN defined: flush_cnt=1 and bubble_cnt=0.
- Hold: hold_e=1 for 3 cycles with D inputs changing every cycle -> all E outputs stay constant and stall_d=1 throughout. On release, the current D values are captured; with the macro defined, hold_cnt=3.
- Invalid decode: valid_d=0 with RegWriteD=1 and MemWriteD=1 -> valid_e=0, RegWriteE=0, MemWriteE=0.
